// File: rtl/inc_rate_encoder.sv
// Sigma-delta inc pulse encoder: one valid/ready value per frame becomes a
// WINDOW-step inc train of density value/2^VALUE_WIDTH, advanced by prop_in.
// Ports: clk_in, rst_in (async, active-high), prop_in step strobe,
//   value_in/valid_in/ready_out frame handshake, inc pulse, busy_out,
//   done_out end-of-frame pulse, inc_count_out pulses in current/last frame.
module inc_rate_encoder #(
  parameter int VALUE_WIDTH = 8,
  parameter int WINDOW      = 256,
  localparam int CNT_W      = $clog2(WINDOW + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   prop_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic                   inc,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [CNT_W-1:0]       inc_count_out
);

  localparam int STEP_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [STEP_W-1:0] LAST = STEP_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] acc_q, acc_d;
  logic [VALUE_WIDTH-1:0] val_q, val_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [VALUE_WIDTH:0]   sum;
  logic                   carry;

  // Accumulator overflow marks a pulse; the wrapped remainder carries the
  // fractional error forward so pulses are spread evenly.
  assign sum   = {1'b0, acc_q} + {1'b0, val_q};
  assign carry = sum[VALUE_WIDTH];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      acc_q   <= '0;
      val_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      val_q   <= val_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    val_d     = val_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    ready_out = 1'b0;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    inc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          val_d   = value_in;
          acc_d   = '0;
          step_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_out = 1'b1;
        inc      = prop_in & carry;
        if (prop_in) begin
          acc_d = sum[VALUE_WIDTH-1:0];
          cnt_d = cnt_q + CNT_W'(carry);
          // Hold on the last step so step never leaves 0..WINDOW-1.
          if (step_q == LAST) begin
            state_d = DONE;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      DONE: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign inc_count_out = cnt_q;

endmodule
